// File: rtl/pmem_loader.sv
// Framed byte-stream loader that writes 32-bit words into program memory while holding the core.
// Optional trailing XOR checksum byte is enabled by defining PMEM_LOADER_CSUM_EN.
module pmem_loader #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              pmem_we_c0,
  output logic [ADDR_W-1:0] pmem_addr_c0,
  output logic [31:0]       pmem_wdata_c0,
  output logic              hold_core,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StHdrAddr,
    StHdrCnt,
    StData,
    StCsum,
    StEnd
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        hdr_idx_q, hdr_idx_d;
  logic [31:0]       addr_raw_q, addr_raw_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [23:0]       word_asm_q, word_asm_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              res_err_q, res_err_d;
`ifdef PMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic        in_frame;
  logic        timeout;
  logic [15:0] n_words;
  logic        unused_addr_hi;

  assign byte_ready = (state_q != StEnd);
  assign accept     = byte_valid & byte_ready;
  assign n_words    = {byte_data, cnt_lo_q};
  // Byte address bits above the PMEM word range are deliberately ignored.
  assign unused_addr_hi = ^addr_raw_q[31:ADDR_W+2];

  assign in_frame = (state_q == StHdrAddr) || (state_q == StHdrCnt) ||
                    (state_q == StData)    || (state_q == StCsum);
  assign timeout  = in_frame && !accept && (idle_q == IdleW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    addr_raw_d   = addr_raw_q;
    cnt_lo_d     = cnt_lo_q;
    byte_idx_d   = byte_idx_q;
    words_left_d = words_left_q;
    word_asm_d   = word_asm_q;
    waddr_d      = waddr_q;
    we_d         = 1'b0;
    paddr_d      = paddr_q;
    wdata_d      = wdata_q;
    res_err_d    = res_err_q;
    idle_d       = '0;
`ifdef PMEM_LOADER_CSUM_EN
    csum_d       = csum_q;
`endif

    if (in_frame && !accept) begin
      idle_d = idle_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept && (byte_data == SyncByte)) begin
          state_d    = StHdrAddr;
          hdr_idx_d  = '0;
          byte_idx_d = '0;
          res_err_d  = 1'b0;
`ifdef PMEM_LOADER_CSUM_EN
          csum_d     = '0;
`endif
        end
      end

      StHdrAddr: begin
        if (accept) begin
          // Little-endian: shift each new byte in at the top.
          addr_raw_d = {byte_data, addr_raw_q[31:8]};
          hdr_idx_d  = hdr_idx_q + 1'b1;
          if (hdr_idx_q == 2'd3) begin
            state_d   = StHdrCnt;
            hdr_idx_d = '0;
          end
        end
      end

      StHdrCnt: begin
        if (accept) begin
          if (hdr_idx_q == 2'd0) begin
            cnt_lo_d  = byte_data;
            hdr_idx_d = 2'd1;
          end else if (addr_raw_q[1:0] != 2'b00) begin
            state_d   = StEnd;
            res_err_d = 1'b1;
          end else if (n_words == 16'd0) begin
`ifdef PMEM_LOADER_CSUM_EN
            state_d = StCsum;
`else
            state_d = StEnd;
`endif
          end else begin
            state_d      = StData;
            words_left_d = n_words;
            waddr_d      = addr_raw_q[ADDR_W+1:2];
            byte_idx_d   = '0;
          end
        end
      end

      StData: begin
        if (accept) begin
`ifdef PMEM_LOADER_CSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          word_asm_d = {byte_data, word_asm_q[23:8]};
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            we_d         = 1'b1;
            wdata_d      = {byte_data, word_asm_q};
            paddr_d      = waddr_q;
            waddr_d      = waddr_q + 1'b1;
            words_left_d = words_left_q - 16'd1;
            if (words_left_q == 16'd1) begin
`ifdef PMEM_LOADER_CSUM_EN
              state_d = StCsum;
`else
              state_d = StEnd;
`endif
            end
          end
        end
      end

`ifdef PMEM_LOADER_CSUM_EN
      StCsum: begin
        if (accept) begin
          state_d   = StEnd;
          res_err_d = (byte_data != csum_q);
        end
      end
`endif

      StEnd: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (timeout) begin
      state_d   = StEnd;
      res_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hdr_idx_q    <= '0;
      addr_raw_q   <= '0;
      cnt_lo_q     <= '0;
      byte_idx_q   <= '0;
      words_left_q <= '0;
      word_asm_q   <= '0;
      waddr_q      <= '0;
      we_q         <= 1'b0;
      paddr_q      <= '0;
      wdata_q      <= '0;
      idle_q       <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      addr_raw_q   <= addr_raw_d;
      cnt_lo_q     <= cnt_lo_d;
      byte_idx_q   <= byte_idx_d;
      words_left_q <= words_left_d;
      word_asm_q   <= word_asm_d;
      waddr_q      <= waddr_d;
      we_q         <= we_d;
      paddr_q      <= paddr_d;
      wdata_q      <= wdata_d;
      idle_q       <= idle_d;
      res_err_q    <= res_err_d;
    end
  end

`ifdef PMEM_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign pmem_we_c0    = we_q;
  assign pmem_addr_c0  = paddr_q;
  assign pmem_wdata_c0 = wdata_q;
  assign hold_core     = (state_q != StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StEnd) && !res_err_q;
  assign err           = (state_q == StEnd) && res_err_q;

endmodule
